alu_sll_pipe: RTL and testbench

//  Pipelined 32-bit logical shift-left unit: the left-direction counterpart of the ALU's

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_sll_stage.sv | 46 ++++
 rtl/alu_sll_pipe.sv | 74 +++++++
 tb/tb_alu_sll_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants and the payload carried through the shift-left pipeline.
// The ovf field exists only when ALU_SLL_OVF_EN is defined.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int SHAMT_W   = 5;
  localparam int TAG_W     = 5;

  // Shift distance of each stage, largest first; stage k consumes shamt bit (SHAMT_W-1-k).
  localparam int SLL_DIST_TABLE [SHAMT_W] = '{16, 8, 4, 2, 1};

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic [SHAMT_W-1:0]   shamt;
    logic [TAG_W-1:0]     tag;
    logic                 valid;
`ifdef ALU_SLL_OVF_EN
    logic                 ovf;
`endif
  } sll_stage_t;

endpackage

// File: rtl/alu_sll_stage.sv
// One registered stage of the shift-left pipeline: conditional left shift by DIST.
// With ALU_SLL_OVF_EN defined it also accumulates a sticky signed-overflow flag.
module alu_sll_stage
  import alu_pkg::*;
#(
  parameter int DIST    = 1,
  parameter int SEL_BIT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_adv,
  input  sll_stage_t i_stage,
  output sll_stage_t o_stage
);

  sll_stage_t r_stage;
  sll_stage_t w_next;

`ifdef ALU_SLL_OVF_EN
  // Dropped bits plus the new sign bit; with no earlier overflow the current MSB is the original sign.
  logic [DIST:0] w_top;
  assign w_top = i_stage.data[ALU_WIDTH-1 -: DIST+1];
`endif

  always_comb begin
    w_next = i_stage;
    w_next.shamt[SEL_BIT] = 1'b0;
    if (i_stage.shamt[SEL_BIT]) begin
      w_next.data = i_stage.data << DIST;
`ifdef ALU_SLL_OVF_EN
      w_next.ovf = i_stage.ovf | ((w_top != '0) && (w_top != '1));
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stage <= '0;
    end else if (i_adv) begin
      r_stage <= w_next;
    end
  end

  assign o_stage = r_stage;

endmodule

// File: rtl/alu_sll_pipe.sv
// Pipelined logical shift-left unit: one registered stage per shamt bit, valid/ready on both sides.
// Define ALU_SLL_OVF_EN to add the out_ovf signed-overflow output.
module alu_sll_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = alu_pkg::SHAMT_W,
  parameter int TAG_W   = alu_pkg::TAG_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag
`ifdef ALU_SLL_OVF_EN
  ,
  output logic               out_ovf
`endif
);

  sll_stage_t w_head;
  sll_stage_t w_stageIn  [SHAMT_W];
  sll_stage_t w_stageOut [SHAMT_W];
  sll_stage_t w_last;
  logic       w_adv;
  logic       w_unusedShamt;

  // Whole pipeline moves in lockstep; it only stalls when a finished result is not taken.
  assign w_last   = w_stageOut[SHAMT_W-1];
  assign w_adv    = !w_last.valid || out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_head       = '0;
    w_head.data  = in_a;
    w_head.shamt = in_shamt;
    w_head.tag   = in_tag;
    w_head.valid = in_valid && w_adv;
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_stageIn[k] = w_head;
    end else begin : g_rest
      assign w_stageIn[k] = w_stageOut[k-1];
    end

    alu_sll_stage #(
      .DIST    (SLL_DIST_TABLE[k]),
      .SEL_BIT (SHAMT_W-1-k)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .i_adv   (w_adv),
      .i_stage (w_stageIn[k]),
      .o_stage (w_stageOut[k])
    );
  end

  assign out_valid     = w_last.valid;
  assign out_result    = w_last.data;
  assign out_tag       = w_last.tag;
  assign w_unusedShamt = ^w_last.shamt;
`ifdef ALU_SLL_OVF_EN
  assign out_ovf       = w_last.ovf;
`endif

endmodule

// File: tb/tb_alu_sll_pipe.sv
// Self-checking bench for alu_sll_pipe: directed scenarios plus a randomized run against a queue model.
// Exercises out_ovf as well when ALU_SLL_OVF_EN is defined.
`timescale 1ns/1ps
module tb_alu_sll_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [4:0]  in_shamt = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
`ifdef ALU_SLL_OVF_EN
  logic        out_ovf;
`endif

  typedef struct {
    logic [31:0] result;
    logic [4:0]  tag;
    logic        ovf;
  } exp_t;

  exp_t        expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          cycleNo = 0;
  int          segXfers = 0;
  int          segFirst = -1;
  int          segLast = -1;
  logic [31:0] lastResult = '0;

  alu_sll_pipe dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
`ifdef ALU_SLL_OVF_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  always #5 clock = ~clock;

  // Reference: multiply by 2^shamt in 64-bit arithmetic, keep the low 32 bits.
  function automatic logic [31:0] refShift(logic [31:0] a, int sh);
    longint unsigned p;
    p = 64'(a) * (64'd1 << sh);
    return p[31:0];
  endfunction

  // Reference: signed overflow when a*2^shamt does not fit a 32-bit signed value.
  function automatic logic refOvf(logic [31:0] a, int sh);
    longint s;
    s = longint'($signed(a)) * (longint'(1) << sh);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic checkOutput(string name, logic [31:0] observed, logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(logic v, logic [31:0] a, logic [4:0] sh, logic [4:0] tag);
    in_valid = v;
    in_a     = a;
    in_shamt = sh;
    in_tag   = tag;
  endtask

  task automatic startSegment();
    segXfers = 0;
    segFirst = -1;
    segLast  = -1;
  endtask

  // Samples handshakes just before the edge, updates the model, then advances one clock.
  task automatic stepClock();
    exp_t e;
    #1;
    if (!reset) begin
      expQ.delete();
    end else begin
      if (out_valid && out_ready) begin
        segXfers++;
        if (segFirst < 0) segFirst = cycleNo;
        segLast    = cycleNo;
        lastResult = out_result;
        checkOutput("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("sb_result", out_result, e.result);
          checkOutput("sb_tag", 32'(out_tag), 32'(e.tag));
`ifdef ALU_SLL_OVF_EN
          checkOutput("sb_ovf", 32'(out_ovf), 32'(e.ovf));
`endif
        end
      end
      if (in_valid && in_ready) begin
        e.result = refShift(in_a, int'(in_shamt));
        e.tag    = in_tag;
        e.ovf    = refOvf(in_a, int'(in_shamt));
        expQ.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    cycleNo++;
  endtask

  task automatic drain(int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < maxCycles) begin
      stepClock();
      n++;
    end
    checkOutput("drain_done", 32'(expQ.size() == 0 && !out_valid), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [31:0] holdRes;
    logic [4:0]  holdTag;

    $display("[TB] reset with in_valid high");
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd3, 5'd1);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_result", out_result, 32'd0);
      checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    end
    applyStimulus(1'b0, '0, '0, '0);
    reset = 1'b1;

    $display("[TB] single op latency");
    startSegment();
    applyStimulus(1'b1, 32'h0000_0001, 5'd31, 5'd7);
    stepClock();
    applyStimulus(1'b0, '0, '0, '0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      stepClock();
      lat++;
    end
    checkOutput("single_latency", 32'(lat), 32'd5);
    checkOutput("single_result", out_result, 32'h8000_0000);
    checkOutput("single_tag", 32'(out_tag), 32'd7);
    stepClock();
    checkOutput("single_valid_once", 32'(out_valid), 32'd0);
    drain(10);

    $display("[TB] streaming shamt 0..7");
    startSegment();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 32'hF0F0_1234, 5'(k), 5'(k + 10));
      stepClock();
    end
    applyStimulus(1'b0, '0, '0, '0);
    drain(20);
    checkOutput("stream_count", 32'(segXfers), 32'd8);
    checkOutput("stream_no_gaps", 32'(segLast - segFirst + 1), 32'd8);

    $display("[TB] backpressure");
    startSegment();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h0000_00A5 + 32'(k), 5'(k + 2), 5'(k + 20));
      stepClock();
    end
    applyStimulus(1'b0, '0, '0, '0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      stepClock();
      lat++;
    end
    out_ready = 1'b0;
    holdRes = out_result;
    holdTag = out_tag;
    checkOutput("bp_first_result", holdRes, 32'h0000_0294);
    applyStimulus(1'b1, 32'h1234_5678, 5'd8, 5'd30);
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
      checkOutput("bp_result_held", out_result, holdRes);
      checkOutput("bp_tag_held", 32'(out_tag), 32'(holdTag));
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    stepClock();
    applyStimulus(1'b0, '0, '0, '0);
    drain(30);
    checkOutput("bp_count", 32'(segXfers), 32'd4);

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h0000_0F00 + 32'(k), 5'(k), 5'(k + 1));
      stepClock();
    end
    applyStimulus(1'b0, '0, '0, '0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_result", out_result, 32'd0);
    checkOutput("midrst_out_tag", 32'(out_tag), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    stepClock();
    reset = 1'b1;
    startSegment();
    applyStimulus(1'b1, 32'h0000_0003, 5'd4, 5'd9);
    stepClock();
    applyStimulus(1'b0, '0, '0, '0);
    drain(20);
    checkOutput("midrst_count", 32'(segXfers), 32'd1);
    checkOutput("midrst_result", lastResult, 32'h0000_0030);

`ifdef ALU_SLL_OVF_EN
    $display("[TB] overflow flag");
    applyStimulus(1'b1, 32'h4000_0000, 5'd1, 5'd1);
    stepClock();
    applyStimulus(1'b1, 32'hC000_0000, 5'd1, 5'd2);
    stepClock();
    applyStimulus(1'b1, 32'h0000_0001, 5'd4, 5'd3);
    stepClock();
    applyStimulus(1'b0, '0, '0, '0);
    drain(20);
`endif

    $display("[TB] randomized traffic");
    startSegment();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'h8000_0000;
        2:       a = 32'(1) << $urandom_range(0, 31);
        default: a = $urandom;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, a, 5'($urandom_range(0, 31)), 5'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      stepClock();
    end
    applyStimulus(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    drain(50);
    checkOutput("random_traffic_seen", 32'(segXfers > 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
